color_reg_port: RTL and testbench
=================================

// Module: color_reg_port
// PURPOSE
//  CPU-side access port for the 32x16 dual-port colour register RAM (2 palettes x 16 colours).
//  Index register plus auto-incrementing data port: three byte writes (R,G,B) assemble one 12-bit entry
//  and commit it on RAM port A; three byte reads return R,G,B of an entry fetched from RAM.
//  Sits between the extended register decoder and port A; the pixel path keeps port B.
// PARAMETERS
//  addr_width  5   RAM address bits (entries = 2**addr_width)
//  data_width  16  RAM word width; entry = {4'b0, R[3:0], G[3:0], B[3:0]}
// PORTS
//  clk           in   1           system clock, all logic on posedge
//  rst_n         in   1           asynchronous, active-low reset
//  cpu_we        in   1           one-cycle write strobe
//  cpu_re        in   1           one-cycle read strobe
//  cpu_sel       in   1           0 = index register, 1 = data port
//  cpu_din       in   8           write data (data port uses [3:0] only)
//  cpu_dout      out  8           read data, valid while cpu_rd_valid
//  cpu_rd_valid  out  1           one-cycle pulse, cpu_dout valid
//  busy          out  1           high in any non-IDLE state
//  ram_we        out  1           port A write enable
//  ram_addr      out  addr_width  port A address
//  ram_din       out  data_width  port A write data
//  ram_dout      in   data_width  port A read data (1-cycle registered RAM)
// BEHAVIOUR
//  Reset: state IDLE, index=0, phase=0, dir=WRITE, shadow=0; all outputs 0. Reset mid-operation
//   aborts immediately (ram_we drops asynchronously); no partial commit survives.
//  All outputs registered. Strobes accepted only in IDLE; strobes while busy are dropped.
//  cpu_we and cpu_re in same cycle: write taken, read dropped.
//  Index write: index<=cpu_din[addr_width-1:0], phase<=0, partial triplet discarded. No RAM access.
//  Index read: cpu_dout={zero-pad,index}, cpu_rd_valid 1 cycle later; no side effects.
//  Data write (dir switches to WRITE; if dir was READ, phase<=0 first):
//   phase0 latch R, phase1 latch G -> phase++ ; stay IDLE.
//   phase2 -> WR_COMMIT: ram_we=1, ram_addr=index, ram_din={4'b0,R,G,cpu_din[3:0]} for exactly 1 cycle;
//   on exit index<=index+1 (wrap 2**addr_width-1 -> 0), phase<=0, -> IDLE.
//  Data read (dir switches to READ; if dir was WRITE, phase<=0 first):
//   phase0 -> RD_ISSUE (ram_addr=index, ram_we=0) -> RD_WAIT (ram_dout valid) -> latch shadow,
//    cpu_dout={4'b0,R}, cpu_rd_valid=1 in following cycle (3 cycles after strobe), phase<=1.
//   phase1/2: cpu_dout={4'b0,G|B} from shadow, rd_valid 1 cycle after strobe, no RAM access.
//   after phase2 read: index++ (same wrap), phase<=0.
//  States: IDLE, WR_COMMIT, RD_ISSUE, RD_WAIT. Other transitions return to IDLE.
//  ram_din held 0 and ram_we 0 outside WR_COMMIT; ram_addr tracks index.
//  Port B writes to same entry concurrently: not arbitrated here; last-writer semantics of the RAM.
// STRUCTURE
//  common.vh: state encodings, entry field positions (R[11:8], G[7:4], B[3:0]), CPU_SEL_INDEX/DATA.
//  Single module, no sub-module; the RAM itself is instantiated by the parent, not here.
// TESTING
//  Reset then idx wr 0x05, data wr 0x0A,0x0B,0x0C -> one ram_we pulse, addr 5, din 16'h0ABC; index 6.
//  idx wr 0x1F, data wr 1,2,3 -> write addr 31 din 16'h0123; next triplet writes addr 0 (wrap).
//  RAM[3]=16'h0456, idx wr 3, data rd x3 -> 8'h04 (3 cycles after strobe), 8'h05, 8'h06; index 4.
//  data wr 0x0F,0x0E then idx wr 7 then data wr 1,2,3 -> only write is addr 7 din 16'h0123.
//  data rd once (R) then data wr 9,8,7 -> phase reset on dir switch; write din 16'h0987 at index.
//  assert rst_n low during WR_COMMIT -> ram_we 0 immediately, index 0, no RAM change; we+re same cycle -> read dropped.

Source files
------------

// File: rtl/color_reg_port_pkg.sv
// ---------------------------------------------------------------------------
// color_reg_port_pkg
// Shared definitions for the CPU-side colour register access port:
//   - controller state encoding
//   - access direction (write / read triplet in progress)
//   - CPU select decoding (index register vs. data port)
//   - colour entry field layout: R[11:8], G[7:4], B[3:0]
//   - pack_entry helper building a 12-bit entry from three nibbles
// ---------------------------------------------------------------------------
package color_reg_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_COMMIT = 2'd1,
    ST_RD_ISSUE  = 2'd2,
    ST_RD_WAIT   = 2'd3
  } state_e;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } dir_e;

  localparam logic CPU_SEL_INDEX = 1'b0;
  localparam logic CPU_SEL_DATA  = 1'b1;

  localparam int CH_W    = 4;
  localparam int ENTRY_W = 12;
  localparam int R_LSB   = 8;
  localparam int G_LSB   = 4;
  localparam int B_LSB   = 0;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [CH_W-1:0] r,
                                                     input logic [CH_W-1:0] g,
                                                     input logic [CH_W-1:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/color_reg_port.sv
// ---------------------------------------------------------------------------
// color_reg_port
// CPU-side access port for the dual-port colour register RAM (port A side).
// An index register selects the entry; the data port auto-increments through
// R, G, B nibbles. Three data writes assemble and commit one 12-bit entry;
// three data reads return R, G, B of an entry fetched once from the RAM.
//
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   cpu_we, cpu_re  one-cycle write / read strobes (accepted only when idle)
//   cpu_sel         0 = index register, 1 = data port
//   cpu_din         CPU write data (data port uses [3:0])
//   cpu_dout        CPU read data, valid while cpu_rd_valid
//   cpu_rd_valid    one-cycle read data valid pulse
//   busy            high while the controller is not idle
//   ram_we/addr/din port A write enable, address, write data
//   ram_dout        port A read data (RAM output is registered, 1 cycle)
// ---------------------------------------------------------------------------
module color_reg_port
  import color_reg_port_pkg::*;
#(
  parameter int addr_width = 5,
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  input  logic                  cpu_sel,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  cpu_rd_valid,
  output logic                  busy,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  logic [1:0]            phase_q, phase_d;
  logic [addr_width-1:0] index_q, index_d;
  logic [CH_W-1:0]       r_q, r_d;
  logic [CH_W-1:0]       g_q, g_d;
  logic [ENTRY_W-1:0]    shadow_q, shadow_d;
  logic [7:0]            cpu_dout_q, cpu_dout_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  busy_q, busy_d;
  logic                  ram_we_q, ram_we_d;
  logic [addr_width-1:0] ram_addr_q, ram_addr_d;
  logic [data_width-1:0] ram_din_q, ram_din_d;
  logic [1:0]            eff_phase;
  logic [addr_width-1:0] index_inc;

  // Bits the port never looks at; kept visible so the intent is explicit.
  logic unused_bits;
  assign unused_bits = ^{cpu_din[7:addr_width], ram_dout[data_width-1:ENTRY_W]};

  // Entry index wraps naturally at 2**addr_width.
  assign index_inc = index_q + {{(addr_width-1){1'b0}}, 1'b1};

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    phase_d    = phase_q;
    index_d    = index_q;
    r_d        = r_q;
    g_d        = g_q;
    shadow_d   = shadow_q;
    cpu_dout_d = cpu_dout_q;
    rd_valid_d = 1'b0;
    ram_we_d   = 1'b0;
    ram_din_d  = {data_width{1'b0}};
    eff_phase  = phase_q;

    case (state_q)
      ST_IDLE: begin
        // Write wins when both strobes arrive together.
        if (cpu_we) begin
          if (cpu_sel == CPU_SEL_INDEX) begin
            index_d = cpu_din[addr_width-1:0];
            phase_d = 2'd0;
          end else begin
            // A direction change restarts the triplet from R.
            eff_phase = (dir_q == DIR_READ) ? 2'd0 : phase_q;
            dir_d     = DIR_WRITE;
            case (eff_phase)
              2'd0: begin
                r_d     = cpu_din[CH_W-1:0];
                phase_d = 2'd1;
              end
              2'd1: begin
                g_d     = cpu_din[CH_W-1:0];
                phase_d = 2'd2;
              end
              default: begin
                state_d   = ST_WR_COMMIT;
                ram_we_d  = 1'b1;
                ram_din_d = {{(data_width-ENTRY_W){1'b0}},
                             pack_entry(r_q, g_q, cpu_din[CH_W-1:0])};
                phase_d   = 2'd2;
              end
            endcase
          end
        end else if (cpu_re) begin
          if (cpu_sel == CPU_SEL_INDEX) begin
            cpu_dout_d = {{(8-addr_width){1'b0}}, index_q};
            rd_valid_d = 1'b1;
          end else begin
            eff_phase = (dir_q == DIR_WRITE) ? 2'd0 : phase_q;
            dir_d     = DIR_READ;
            case (eff_phase)
              2'd0: begin
                state_d = ST_RD_ISSUE;
                phase_d = 2'd0;
              end
              2'd1: begin
                cpu_dout_d = {4'b0000, shadow_q[G_LSB +: CH_W]};
                rd_valid_d = 1'b1;
                phase_d    = 2'd2;
              end
              default: begin
                cpu_dout_d = {4'b0000, shadow_q[B_LSB +: CH_W]};
                rd_valid_d = 1'b1;
                phase_d    = 2'd0;
                index_d    = index_inc;
              end
            endcase
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_COMMIT: begin
        state_d = ST_IDLE;
        index_d = index_inc;
        phase_d = 2'd0;
      end
      ST_RD_ISSUE: begin
        // RAM samples the address at the end of this cycle.
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        shadow_d   = ram_dout[ENTRY_W-1:0];
        cpu_dout_d = {4'b0000, ram_dout[R_LSB +: CH_W]};
        rd_valid_d = 1'b1;
        phase_d    = 2'd1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    ram_addr_d = index_d;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_WRITE;
      phase_q    <= 2'd0;
      index_q    <= {addr_width{1'b0}};
      r_q        <= {CH_W{1'b0}};
      g_q        <= {CH_W{1'b0}};
      shadow_q   <= {ENTRY_W{1'b0}};
      cpu_dout_q <= 8'h00;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= {addr_width{1'b0}};
      ram_din_q  <= {data_width{1'b0}};
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      phase_q    <= phase_d;
      index_q    <= index_d;
      r_q        <= r_d;
      g_q        <= g_d;
      shadow_q   <= shadow_d;
      cpu_dout_q <= cpu_dout_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign cpu_dout     = cpu_dout_q;
  assign cpu_rd_valid = rd_valid_q;
  assign busy         = busy_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_din      = ram_din_q;

endmodule

// File: tb/tb_color_reg_port.sv
// ---------------------------------------------------------------------------
// tb_color_reg_port
// Directed self-checking bench for color_reg_port with a 32x16 registered
// RAM model on port A and a backdoor for preloading entries.
// ---------------------------------------------------------------------------
module tb_color_reg_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_we, cpu_re, cpu_sel;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_rd_valid, busy, ram_we;
  logic [4:0]  ram_addr;
  logic [15:0] ram_din, ram_dout;

  logic [15:0] mem [0:31];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = 5'd0;
  logic [15:0] bd_data = 16'h0000;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  logic [4:0]  last_addr = 5'd0;
  logic [15:0] last_din = 16'h0000;

  color_reg_port #(.addr_width(5), .data_width(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_sel(cpu_sel), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_rd_valid(cpu_rd_valid), .busy(busy), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Registered RAM model (port A) with backdoor preload and write monitor.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wr_count      <= wr_count + 1;
      last_addr     <= ram_addr;
      last_din      <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic cpu_wr(input logic sel, input logic [7:0] d);
    @(negedge clk); cpu_we = 1'b1; cpu_sel = sel; cpu_din = d;
    @(negedge clk); cpu_we = 1'b0;
  endtask

  task automatic data_wr3(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    cpu_wr(1'b1, r); cpu_wr(1'b1, g); cpu_wr(1'b1, b);
    repeat (2) @(negedge clk);
  endtask

  // Read strobe; lat = cycles from strobe to rd_valid (0 on timeout).
  task automatic cpu_rd(input logic sel, output logic [7:0] d, output int lat);
    d = 8'h00; lat = 0;
    @(negedge clk); cpu_re = 1'b1; cpu_sel = sel;
    @(negedge clk); cpu_re = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (cpu_rd_valid === 1'b1) begin
        lat = i; d = cpu_dout; break;
      end
      @(negedge clk);
    end
  endtask

  task automatic backdoor(input logic [4:0] a, input logic [15:0] v);
    @(negedge clk); bd_we = 1'b1; bd_addr = a; bd_data = v;
    @(negedge clk); bd_we = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d; int lat;
    rst_n = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_sel = 1'b0; cpu_din = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if ({ram_we, busy, cpu_rd_valid} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b expected 000", {ram_we, busy, cpu_rd_valid}); end
    checks++; if ({ram_addr, ram_din, cpu_dout} !== 29'd0) begin errors++; $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", ram_addr, ram_din, cpu_dout); end
    rst_n = 1'b1;
    cpu_rd(1'b0, d, lat);
    checks++; if (d !== 8'h00 || lat !== 1) begin errors++; $display("FAIL reset_index: got %h lat %0d expected 00 lat 1", d, lat); end
  endtask

  task automatic test_write_basic;
    logic [7:0] d; int lat; int w0;
    w0 = wr_count;
    cpu_wr(1'b0, 8'h05);
    cpu_wr(1'b1, 8'h0A); cpu_wr(1'b1, 8'h0B); cpu_wr(1'b1, 8'h0C);
    checks++; if ({ram_we, busy} !== 2'b11 || ram_addr !== 5'd5 || ram_din !== 16'h0ABC) begin errors++; $display("FAIL commit_outputs: got we%b busy%b addr %h din %h expected we1 busy1 addr 05 din 0abc", ram_we, busy, ram_addr, ram_din); end
    repeat (2) @(negedge clk);
    checks++; if (wr_count - w0 !== 1 || last_addr !== 5'd5 || last_din !== 16'h0ABC) begin errors++; $display("FAIL write_basic: got %0d writes addr %h din %h expected 1 writes addr 05 din 0abc", wr_count - w0, last_addr, last_din); end
    checks++; if (ram_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL commit_one_cycle: got we%b busy%b expected we0 busy0", ram_we, busy); end
    cpu_rd(1'b0, d, lat);
    checks++; if (d !== 8'h06) begin errors++; $display("FAIL index_after_write: got %h expected 06", d); end
  endtask

  task automatic test_wrap;
    int w0;
    w0 = wr_count;
    cpu_wr(1'b0, 8'h1F);
    data_wr3(8'h01, 8'h02, 8'h03);
    checks++; if (wr_count - w0 !== 1 || last_addr !== 5'd31 || last_din !== 16'h0123) begin errors++; $display("FAIL write_top: got %0d writes addr %h din %h expected 1 writes addr 1f din 0123", wr_count - w0, last_addr, last_din); end
    data_wr3(8'h04, 8'h05, 8'h06);
    checks++; if (wr_count - w0 !== 2 || last_addr !== 5'd0 || last_din !== 16'h0456) begin errors++; $display("FAIL write_wrap: got %0d writes addr %h din %h expected 2 writes addr 00 din 0456", wr_count - w0, last_addr, last_din); end
  endtask

  task automatic test_read;
    logic [7:0] d; int lat;
    backdoor(5'd3, 16'h0456);
    cpu_wr(1'b0, 8'h03);
    cpu_rd(1'b1, d, lat);
    checks++; if (d !== 8'h04 || lat !== 3) begin errors++; $display("FAIL read_r: got %h lat %0d expected 04 lat 3", d, lat); end
    cpu_rd(1'b1, d, lat);
    checks++; if (d !== 8'h05 || lat !== 1) begin errors++; $display("FAIL read_g: got %h lat %0d expected 05 lat 1", d, lat); end
    cpu_rd(1'b1, d, lat);
    checks++; if (d !== 8'h06 || lat !== 1) begin errors++; $display("FAIL read_b: got %h lat %0d expected 06 lat 1", d, lat); end
    cpu_rd(1'b0, d, lat);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL index_after_read: got %h expected 04", d); end
  endtask

  task automatic test_partial_discard;
    int w0;
    w0 = wr_count;
    cpu_wr(1'b1, 8'h0F); cpu_wr(1'b1, 8'h0E);
    cpu_wr(1'b0, 8'h07);
    data_wr3(8'h01, 8'h02, 8'h03);
    checks++; if (wr_count - w0 !== 1 || last_addr !== 5'd7 || last_din !== 16'h0123) begin errors++; $display("FAIL partial_discard: got %0d writes addr %h din %h expected 1 writes addr 07 din 0123", wr_count - w0, last_addr, last_din); end
  endtask

  task automatic test_dir_switch;
    logic [7:0] d; int lat; int w0;
    backdoor(5'd8, 16'h0ABC);
    cpu_rd(1'b1, d, lat);
    checks++; if (d !== 8'h0A || lat !== 3) begin errors++; $display("FAIL switch_read_r: got %h lat %0d expected 0a lat 3", d, lat); end
    w0 = wr_count;
    data_wr3(8'h09, 8'h08, 8'h07);
    checks++; if (wr_count - w0 !== 1 || last_addr !== 5'd8 || last_din !== 16'h0987) begin errors++; $display("FAIL dir_switch_write: got %0d writes addr %h din %h expected 1 writes addr 08 din 0987", wr_count - w0, last_addr, last_din); end
  endtask

  task automatic test_we_re_same;
    logic [7:0] d; int lat; int seen;
    seen = 0;
    @(negedge clk); cpu_we = 1'b1; cpu_re = 1'b1; cpu_sel = 1'b0; cpu_din = 8'h12;
    @(negedge clk); cpu_we = 1'b0; cpu_re = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_rd_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL we_re_read_dropped: got %0d valid pulses expected 0", seen); end
    cpu_rd(1'b0, d, lat);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL we_re_write_taken: got %h expected 12", d); end
  endtask

  task automatic test_busy_drop;
    logic [7:0] d; int lat; int seen;
    seen = 0;
    cpu_wr(1'b0, 8'h02);
    @(negedge clk); cpu_re = 1'b1; cpu_sel = 1'b1;
    @(negedge clk); cpu_re = 1'b0; cpu_we = 1'b1; cpu_sel = 1'b0; cpu_din = 8'h15;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_read: got %b expected 1", busy); end
    @(negedge clk); cpu_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_rd_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL busy_read_valid: got %0d valid pulses expected 1", seen); end
    cpu_rd(1'b0, d, lat);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL busy_strobe_dropped: got %h expected 02", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; int lat; int w0;
    backdoor(5'd10, 16'h0777);
    w0 = wr_count;
    cpu_wr(1'b0, 8'h0A);
    cpu_wr(1'b1, 8'h01); cpu_wr(1'b1, 8'h02); cpu_wr(1'b1, 8'h03);
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL mid_commit_active: got %b expected 1", ram_we); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0 || busy !== 1'b0 || ram_addr !== 5'd0) begin errors++; $display("FAIL reset_async: got we%b busy%b addr %h expected we0 busy0 addr 00", ram_we, busy, ram_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem[10] !== 16'h0777 || wr_count - w0 !== 0) begin errors++; $display("FAIL reset_no_commit: got mem %h writes %0d expected mem 0777 writes 0", mem[10], wr_count - w0); end
    cpu_rd(1'b0, d, lat);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mid_index: got %h expected 00", d); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_wrap();
    test_read();
    test_partial_discard();
    test_dir_switch();
    test_we_re_same();
    test_busy_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
